// File: rtl/dpram_stream_reader.sv
// dpram_stream_reader
//   Read-side engine for one port of a dual-port RAM. A start command latches a
//   base address and a word count. The engine then reads the words from the base
//   address upward, one per cycle, and presents them as a valid/ready stream.
//   The final word of the transfer is flagged with out_last. The engine absorbs
//   arbitrary consumer backpressure, and it never drops or repeats a word.
//
// Ports
//   clock, reset_n        single clock; asynchronous active-low reset
//   start, base_addr,     transfer request; base_addr and length are sampled
//   length                only while idle
//   abort                 cancel the running transfer at the next edge
//   busy, done            transfer running / one-cycle completion pulse
//   mem_address, mem_wren, RAM port (read-only use; write controls held at 0)
//   mem_data, mem_q       mem_q is valid one cycle after mem_address
//   out_data, out_valid,  output stream; a word moves when out_valid & out_ready
//   out_ready, out_last
module dpram_stream_reader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_wren,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
  logic                  inflight_q, inflight_d;
  logic                  inflight_last_q, inflight_last_d;
  logic [1:0]            buf_count_q, buf_count_d;
  logic [DATA_WIDTH-1:0] buf0_data_q, buf0_data_d;
  logic [DATA_WIDTH-1:0] buf1_data_q, buf1_data_d;
  logic                  buf0_last_q, buf0_last_d;
  logic                  buf1_last_q, buf1_last_d;
  logic                  done_q, done_d;

  logic       pop;
  logic       issue;
  logic [2:0] occupancy;
  logic [1:0] cnt;

  assign busy        = (state_q == S_RUN);
  assign done        = done_q;
  assign mem_address = rd_ptr_q;
  assign mem_wren    = 1'b0;
  assign mem_data    = '0;
  assign out_valid   = (buf_count_q != 2'd0);
  assign out_data    = buf0_data_q;
  // Slot 0 can hold a stale last flag once it has been drained, so qualify it.
  assign out_last    = out_valid & buf0_last_q;

  assign pop = out_valid & out_ready;
  // Words already buffered plus the word arriving on mem_q, less the word
  // leaving this cycle. A new read is issued only if it is sure to have a slot.
  assign occupancy = {1'b0, buf_count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue = (state_q == S_RUN) && (remaining_q != '0) && (occupancy < 3'd2);

  always_comb begin
    state_d         = state_q;
    rd_ptr_d        = rd_ptr_q;
    remaining_d     = remaining_q;
    inflight_d      = inflight_q;
    inflight_last_d = inflight_last_q;
    buf_count_d     = buf_count_q;
    buf0_data_d     = buf0_data_q;
    buf1_data_d     = buf1_data_q;
    buf0_last_d     = buf0_last_q;
    buf1_last_d     = buf1_last_q;
    done_d          = 1'b0;
    cnt             = buf_count_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          rd_ptr_d    = base_addr;
          remaining_d = length;
          if (length == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end
      end

      S_RUN: begin
        if (abort) begin
          // Flush everything. Any word still on mem_q is simply never captured.
          state_d         = S_IDLE;
          remaining_d     = '0;
          inflight_d      = 1'b0;
          inflight_last_d = 1'b0;
          buf_count_d     = 2'd0;
          buf0_last_d     = 1'b0;
          buf1_last_d     = 1'b0;
        end else begin
          if (issue) begin
            rd_ptr_d    = rd_ptr_q + ADDR_WIDTH'(1);
            remaining_d = remaining_q - (ADDR_WIDTH+1)'(1);
          end
          inflight_d      = issue;
          inflight_last_d = issue && (remaining_q == (ADDR_WIDTH+1)'(1));

          // Shift-style FIFO: slot 0 is always the head.
          cnt = buf_count_q - {1'b0, pop};
          if (pop) begin
            buf0_data_d = buf1_data_q;
            buf0_last_d = buf1_last_q;
          end
          if (inflight_q) begin
            if (cnt == 2'd0) begin
              buf0_data_d = mem_q;
              buf0_last_d = inflight_last_q;
            end else begin
              buf1_data_d = mem_q;
              buf1_last_d = inflight_last_q;
            end
            cnt = cnt + 2'd1;
          end
          buf_count_d = cnt;

          if (pop && buf0_last_q) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      rd_ptr_q        <= '0;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      buf_count_q     <= 2'd0;
      buf0_data_q     <= '0;
      buf1_data_q     <= '0;
      buf0_last_q     <= 1'b0;
      buf1_last_q     <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      rd_ptr_q        <= rd_ptr_d;
      remaining_q     <= remaining_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      buf_count_q     <= buf_count_d;
      buf0_data_q     <= buf0_data_d;
      buf1_data_q     <= buf1_data_d;
      buf0_last_q     <= buf0_last_d;
      buf1_last_q     <= buf1_last_d;
      done_q          <= done_d;
    end
  end

endmodule
